// File: rtl/cache_arbiter.sv
// Shares one physical-memory port between the I-cache (A) and D-cache (B).
// Build option: define ARB_ROUND_ROBIN_EN to replace fixed B>A priority with last-grant alternation.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no transaction; arbitrate pending requests
// GRANT_A | I-cache line read in flight from latched command
// GRANT_B | D-cache line read or writeback in flight from latched command
module cache_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic                  pmem_read_a,
   input  logic [ADDR_WIDTH-1:0] pmem_address_a,
   output logic [LINE_WIDTH-1:0] pmem_rdata_a,
   output logic                  pmem_resp_a,

   input  logic                  pmem_read_b,
   input  logic                  pmem_write_b,
   input  logic [ADDR_WIDTH-1:0] pmem_address_b,
   input  logic [LINE_WIDTH-1:0] pmem_wdata_b,
   output logic [LINE_WIDTH-1:0] pmem_rdata_b,
   output logic                  pmem_resp_b,

   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [LINE_WIDTH-1:0] mem_wdata,
   input  logic [LINE_WIDTH-1:0] mem_rdata,
   input  logic                  mem_resp,

   output logic                  arb_busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_A = 2'd1,
      GRANT_B = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic                    rd_q, rd_d;
   logic                    wr_q, wr_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [LINE_WIDTH-1:0]   wdata_q, wdata_d;

   logic                    req_a, req_b;
   logic                    grant_a, grant_b;

`ifdef ARB_ROUND_ROBIN_EN
   localparam logic SIDE_A = 1'b0;
   localparam logic SIDE_B = 1'b1;
   logic                    last_q, last_d;
`endif

   assign req_a = pmem_read_a;
   assign req_b = pmem_read_b | pmem_write_b;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         last_q  <= SIDE_A;
`endif
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
         last_q  <= last_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      grant_a = 1'b0;
      grant_b = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d  = last_q;
`endif

      case (state_q)
         IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
            if (req_a && req_b) begin
               grant_b = (last_q == SIDE_A);
               grant_a = (last_q == SIDE_B);
            end else begin
               grant_a = req_a;
               grant_b = req_b;
            end
`else
            grant_b = req_b;
            grant_a = req_a & ~req_b;
`endif
            if (grant_b) begin
               state_d = GRANT_B;
               // A simultaneous read+write from the D-cache is a writeback.
               wr_d    = pmem_write_b;
               rd_d    = ~pmem_write_b;
               addr_d  = pmem_address_b;
               wdata_d = pmem_write_b ? pmem_wdata_b : '0;
`ifdef ARB_ROUND_ROBIN_EN
               last_d  = SIDE_B;
`endif
            end else if (grant_a) begin
               state_d = GRANT_A;
               rd_d    = 1'b1;
               wr_d    = 1'b0;
               addr_d  = pmem_address_a;
               wdata_d = '0;
`ifdef ARB_ROUND_ROBIN_EN
               last_d  = SIDE_A;
`endif
            end
         end
         GRANT_A, GRANT_B: begin
            if (mem_resp) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign arb_busy    = (state_q != IDLE);

   // Memory side sees only the latched command; idle cycles present zeros.
   assign mem_read    = arb_busy & rd_q;
   assign mem_write   = arb_busy & wr_q;
   assign mem_address = arb_busy ? addr_q  : '0;
   assign mem_wdata   = arb_busy ? wdata_q : '0;

   // A response arriving in the reset cycle belongs to an aborted transaction.
   assign pmem_resp_a  = (state_q == GRANT_A) & mem_resp & ~reset;
   assign pmem_resp_b  = (state_q == GRANT_B) & mem_resp & ~reset;
   assign pmem_rdata_a = pmem_resp_a ? mem_rdata : '0;
   assign pmem_rdata_b = pmem_resp_b ? mem_rdata : '0;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: lone fetch, writeback, contention, input stability,
// mid-transaction reset and stray response. Handles either ARB_ROUND_ROBIN_EN build.
module tb_cache_arbiter;
   localparam int AW = 32;
   localparam int LW = 256;

   logic          clk = 1'b0;
   logic          reset;
   logic          pmem_read_a;
   logic [AW-1:0] pmem_address_a;
   logic [LW-1:0] pmem_rdata_a;
   logic          pmem_resp_a;
   logic          pmem_read_b;
   logic          pmem_write_b;
   logic [AW-1:0] pmem_address_b;
   logic [LW-1:0] pmem_wdata_b;
   logic [LW-1:0] pmem_rdata_b;
   logic          pmem_resp_b;
   logic          mem_read;
   logic          mem_write;
   logic [AW-1:0] mem_address;
   logic [LW-1:0] mem_wdata;
   logic [LW-1:0] mem_rdata;
   logic          mem_resp;
   logic          arb_busy;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [LW-1:0] LINE_AA = {32{8'hAA}};
   localparam logic [LW-1:0] LINE_55 = {32{8'h55}};
   localparam logic [LW-1:0] LINE_WB = {8{32'h1234_5678}};
   localparam logic [LW-1:0] LINE_C3 = {32{8'hC3}};

   cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
      .clk            (clk),
      .reset          (reset),
      .pmem_read_a    (pmem_read_a),
      .pmem_address_a (pmem_address_a),
      .pmem_rdata_a   (pmem_rdata_a),
      .pmem_resp_a    (pmem_resp_a),
      .pmem_read_b    (pmem_read_b),
      .pmem_write_b   (pmem_write_b),
      .pmem_address_b (pmem_address_b),
      .pmem_wdata_b   (pmem_wdata_b),
      .pmem_rdata_b   (pmem_rdata_b),
      .pmem_resp_b    (pmem_resp_b),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_address    (mem_address),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .mem_resp       (mem_resp),
      .arb_busy       (arb_busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $error("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; checks happen 1ns later, far from the rising edge.
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic idle_outputs(input string tag);
      chk({tag, " busy"},   arb_busy,    '0);
      chk({tag, " rd"},     mem_read,    '0);
      chk({tag, " wr"},     mem_write,   '0);
      chk({tag, " addr"},   mem_address, '0);
      chk({tag, " respa"},  pmem_resp_a, '0);
      chk({tag, " respb"},  pmem_resp_b, '0);
   endtask

   initial begin
      reset = 1'b1;
      pmem_read_a = 1'b0; pmem_address_a = '0;
      pmem_read_b = 1'b0; pmem_write_b = 1'b0;
      pmem_address_b = '0; pmem_wdata_b = '0;
      mem_rdata = '0; mem_resp = 1'b0;
      step(); step();
      idle_outputs("reset");
      chk("reset wdata", mem_wdata, '0);
      chk("reset rdataa", pmem_rdata_a, '0);
      chk("reset rdatab", pmem_rdata_b, '0);
      reset = 1'b0;
      step();

      // Lone I-fetch
      pmem_read_a = 1'b1; pmem_address_a = 32'h0000_0100;
      step();
      chk("fetch rd",    mem_read,    1'b1);
      chk("fetch wr",    mem_write,   1'b0);
      chk("fetch addr",  mem_address, 32'h100);
      chk("fetch wdata", mem_wdata,   '0);
      chk("fetch busy",  arb_busy,    1'b1);
      step();
      chk("fetch wait respa", pmem_resp_a, 1'b0);
      chk("fetch wait respb", pmem_resp_b, 1'b0);
      step();
      mem_resp = 1'b1; mem_rdata = LINE_AA;
      #1;
      chk("fetch respa",  pmem_resp_a,  1'b1);
      chk("fetch rdataa", pmem_rdata_a, LINE_AA);
      chk("fetch respb",  pmem_resp_b,  1'b0);
      chk("fetch rdatab", pmem_rdata_b, '0);
      pmem_read_a = 1'b0;
      step();
      mem_resp = 1'b0;
      #1;
      idle_outputs("fetch done");

      // Lone writeback
      pmem_write_b = 1'b1; pmem_address_b = 32'h0000_2040; pmem_wdata_b = LINE_WB;
      step();
      chk("wb wr",    mem_write,   1'b1);
      chk("wb rd",    mem_read,    1'b0);
      chk("wb addr",  mem_address, 32'h2040);
      chk("wb wdata", mem_wdata,   LINE_WB);
      step();
      mem_resp = 1'b1; mem_rdata = LINE_55;
      #1;
      chk("wb respb",  pmem_resp_b,  1'b1);
      chk("wb rdatab", pmem_rdata_b, LINE_55);
      chk("wb respa",  pmem_resp_a,  1'b0);
      pmem_write_b = 1'b0;
      step();
      mem_resp = 1'b0;
      #1;
      idle_outputs("wb done");

      // Contention; B re-requests during the bubble to expose the priority scheme
      pmem_read_a = 1'b1; pmem_address_a = 32'h100;
      pmem_read_b = 1'b1; pmem_address_b = 32'h200; pmem_wdata_b = LINE_C3;
      step();
      chk("cont first addr",  mem_address, 32'h200);
      chk("cont first rd",    mem_read,    1'b1);
      chk("cont first wdata", mem_wdata,   '0);
      step();
      mem_resp = 1'b1; mem_rdata = LINE_55;
      #1;
      chk("cont first respb", pmem_resp_b, 1'b1);
      chk("cont a waits",     pmem_resp_a, 1'b0);
      pmem_address_b = 32'h300;
      step();
      mem_resp = 1'b0;
      #1;
      chk("cont bubble busy", arb_busy, 1'b0);
      chk("cont bubble rd",   mem_read, 1'b0);
      step();
`ifdef ARB_ROUND_ROBIN_EN
      chk("cont second addr", mem_address, 32'h100);
      mem_resp = 1'b1; mem_rdata = LINE_AA;
      #1;
      chk("cont second respa", pmem_resp_a, 1'b1);
      chk("cont second respb", pmem_resp_b, 1'b0);
      pmem_read_a = 1'b0;
      step();
      mem_resp = 1'b0;
      step();
      chk("cont third addr", mem_address, 32'h300);
      mem_resp = 1'b1;
      #1;
      chk("cont third respb", pmem_resp_b, 1'b1);
      pmem_read_b = 1'b0;
`else
      chk("cont second addr", mem_address, 32'h300);
      mem_resp = 1'b1; mem_rdata = LINE_55;
      #1;
      chk("cont second respb", pmem_resp_b, 1'b1);
      chk("cont second respa", pmem_resp_a, 1'b0);
      pmem_read_b = 1'b0;
      step();
      mem_resp = 1'b0;
      step();
      chk("cont third addr", mem_address, 32'h100);
      mem_resp = 1'b1; mem_rdata = LINE_AA;
      #1;
      chk("cont third respa",  pmem_resp_a,  1'b1);
      chk("cont third rdataa", pmem_rdata_a, LINE_AA);
      pmem_read_a = 1'b0;
`endif
      step();
      mem_resp = 1'b0;
      #1;
      idle_outputs("cont done");

      // Input stability after grant; read+write together also means write
      pmem_read_b = 1'b1; pmem_write_b = 1'b1; pmem_address_b = 32'h400; pmem_wdata_b = LINE_C3;
      step();
      chk("rw wr",    mem_write, 1'b1);
      chk("rw rd",    mem_read,  1'b0);
      chk("rw wdata", mem_wdata, LINE_C3);
      pmem_address_b = 32'hFFFF_FFFF; pmem_read_b = 1'b0; pmem_write_b = 1'b0; pmem_wdata_b = '0;
      step();
      chk("stable addr",  mem_address, 32'h400);
      chk("stable wr",    mem_write,   1'b1);
      chk("stable wdata", mem_wdata,   LINE_C3);
      mem_resp = 1'b1;
      #1;
      chk("stable respb", pmem_resp_b, 1'b1);
      step();
      mem_resp = 1'b0;
      #1;
      idle_outputs("stable done");

      // Reset two cycles into GRANT_A, with a late mem_resp in the reset cycle
      pmem_read_a = 1'b1; pmem_address_a = 32'h500;
      step();
      chk("rst granted", arb_busy, 1'b1);
      step();
      reset = 1'b1; mem_resp = 1'b1; mem_rdata = LINE_AA;
      #1;
      chk("rst no respa",   pmem_resp_a,  1'b0);
      chk("rst no rdataa",  pmem_rdata_a, '0);
      step();
      reset = 1'b0; mem_resp = 1'b0; pmem_read_a = 1'b0;
      #1;
      idle_outputs("rst after");
      pmem_read_a = 1'b1; pmem_address_a = 32'h600;
      step();
      chk("rst regrant addr", mem_address, 32'h600);
      chk("rst regrant rd",   mem_read,    1'b1);
      mem_resp = 1'b1;
      #1;
      chk("rst regrant respa", pmem_resp_a, 1'b1);
      pmem_read_a = 1'b0;
      step();
      mem_resp = 1'b0;
      step();

      // Stray response in IDLE
      mem_resp = 1'b1; mem_rdata = LINE_55;
      #1;
      chk("stray respa",  pmem_resp_a,  1'b0);
      chk("stray respb",  pmem_resp_b,  1'b0);
      chk("stray rdatab", pmem_rdata_b, '0);
      step();
      mem_resp = 1'b0;
      #1;
      idle_outputs("stray after");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single physical-memory port between the instruction cache (requester A) and the data cache (requester B) of the pipelined RV32I core.
- The pipeline stages advance on resp_a && resp_b; this block sequences the cache line fills and writebacks behind those responses.
- One memory transaction runs at a time. Each request is latched at grant, so the memory sees stable command, address and data.

Parameters:
- ADDR_WIDTH, 32, width of the byte address on every port.
- LINE_WIDTH, 256, width of one cache line on every data bus.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- pmem_read_a  input  1  I-cache line read request.
- pmem_address_a  input  ADDR_WIDTH  I-cache line address.
- pmem_rdata_a  output  LINE_WIDTH  line returned to the I-cache.
- pmem_resp_a  output  1  I-cache transaction complete, one-cycle pulse.
- pmem_read_b  input  1  D-cache line read request.
- pmem_write_b  input  1  D-cache line writeback request.
- pmem_address_b  input  ADDR_WIDTH  D-cache line address.
- pmem_wdata_b  input  LINE_WIDTH  D-cache writeback data.
- pmem_rdata_b  output  LINE_WIDTH  line returned to the D-cache.
- pmem_resp_b  output  1  D-cache transaction complete, one-cycle pulse.
- mem_read  output  1  read command to physical memory.
- mem_write  output  1  write command to physical memory.
- mem_address  output  ADDR_WIDTH  address to physical memory.
- mem_wdata  output  LINE_WIDTH  write data to physical memory.
- mem_rdata  input  LINE_WIDTH  read data from physical memory.
- mem_resp  input  1  physical memory done, one-cycle pulse.
- arb_busy  output  1  high while a grant is active.

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- States: IDLE, GRANT_A, GRANT_B. State and latch registers update on the rising edge of clk only.
- Reset forces state to IDLE and clears the latched command, address and wdata to 0. Every output is 0 during and after reset until a new grant.
- A reset asserted mid-transaction aborts the transaction. mem_read and mem_write drop the cycle after the reset edge, and no resp is issued.
- In IDLE, request A is pmem_read_a. Request B is pmem_read_b or pmem_write_b.
- IDLE with no request: stay in IDLE. A mem_resp seen in IDLE is ignored.
- IDLE with only A requesting: go to GRANT_A and latch pmem_address_a with the command read.
- IDLE with only B requesting: go to GRANT_B and latch pmem_address_b, pmem_wdata_b and the command.
  - If pmem_write_b and pmem_read_b are both high, the command is write.
- IDLE with A and B both requesting: B wins, by fixed priority.
- In GRANT_x, mem_read, mem_write, mem_address and mem_wdata are driven from the latched registers only.
  - Requester inputs are don't-care after the grant edge.
  - mem_wdata is 0 for a read.
- In GRANT_x with mem_resp high, the same cycle gives:
  - pmem_resp_x = 1;
  - pmem_rdata_x = mem_rdata;
  - next state IDLE.
- Responses are combinational from mem_resp. pmem_resp and pmem_rdata of the non-granted side stay 0 at all times.
- Latency: request high in cycle N (IDLE) puts mem_read/mem_write high in cycle N+1. mem_resp in cycle M gives pmem_resp in cycle M.
- After completion the arbiter spends one IDLE cycle (M+1) before the next grant. The earliest next command is cycle M+2.
- Requesters hold their request until resp. A request still high during the IDLE bubble is re-arbitrated normally.
- A waiting requester sees no response until its own grant completes.
- arb_busy = 1 exactly when state is GRANT_A or GRANT_B.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: a last_grant register is added, reset to A. When both request in IDLE, the side not granted last wins. last_grant updates at each grant edge.
- Undefined: fixed priority B > A applies, and no last_grant register exists.
- Single-requester behaviour is identical in both builds.

Test Plan:
- Lone I-fetch: pmem_read_a=1, address 0x0000_0100. Expect mem_read=1 and mem_address=0x100 the next cycle. Memory returns 0xAA..AA after 3 cycles. Expect pmem_resp_a pulse with pmem_rdata_a=0xAA..AA, and pmem_resp_b=0 throughout.
- Lone writeback: pmem_write_b=1, address 0x0000_2040, wdata 0x1234..5678. Expect mem_write=1 and mem_wdata=0x1234..5678 with mem_read=0. Expect pmem_resp_b on mem_resp, then state IDLE.
- Contention: A (0x100) and B (0x200) both read in the same cycle. Expect B served first, one IDLE bubble, then mem_address=0x100 for A. With ARB_ROUND_ROBIN_EN defined from reset, expect B first (last_grant=A); on repeated contention, expect A next.
- Input stability: after grant, change pmem_address_b to 0xFFFF_FFFF and drop pmem_read_b. Expect mem_address and mem_read to remain at their latched values until mem_resp.
- Reset mid-transaction: assert reset 2 cycles into GRANT_A. Expect mem_read=0, arb_busy=0 and no pmem_resp_a the next cycle. A later request is granted normally.
- Stray response: mem_resp=1 in IDLE. Expect pmem_resp_a=pmem_resp_b=0 and no state change.
